sensor_acquire: RTL

SENSOR_ACQUIRE -- requirements
Module: sensor_acquire

---
 rtl/sensor_acquire_if.sv | 24 ++
 rtl/sensor_acquire.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sensor_acquire_if.sv
// rtl/sensor_acquire_if.sv - sensor sample inputs and averaged-height result handshake
interface sensor_acquire_if;
  logic [7:0] sensor1;
  logic [7:0] sensor2;
  logic [7:0] sensor3;
  logic [7:0] sensor4;
  logic       start;
  logic [7:0] height;
  logic       height_valid;
  logic       height_ready;
  logic       sensor_err;
  logic [2:0] valid_cnt;
  logic       busy;

  modport master (
    output sensor1, sensor2, sensor3, sensor4, start, height_ready,
    input  height, height_valid, sensor_err, valid_cnt, busy
  );

  modport slave (
    input  sensor1, sensor2, sensor3, sensor4, start, height_ready,
    output height, height_valid, sensor_err, valid_cnt, busy
  );
endinterface

// File: rtl/sensor_acquire.sv
// rtl/sensor_acquire.sv - averages non-zero sensor heights with round-half-up restoring division
// Optional SENSOR_ACQ_STABLE_EN: publish only when two consecutive results agree.
module sensor_acquire (
  input  logic           clk,
  input  logic           rst,
  sensor_acquire_if.slave bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_ACC  = 3'd2;
  localparam logic [2:0] ST_DIV  = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;

  logic [2:0]      state;
  logic [3:0][7:0] samples;
  logic [2:0]      acc_idx;
  logic [9:0]      sum;
  logic [2:0]      cnt;
  logic [2:0]      rem;
  logic [9:0]      quo;
  logic [3:0]      div_cnt;
  logic [7:0]      height_r;
  logic            err_r;
  logic [2:0]      vcnt_r;

  logic [7:0]      cur_sample;
  logic [9:0]      dividend;
  logic [12:0]     first_step;
  logic [12:0]     next_step;
  logic            commit;
  logic            publish;
  logic [7:0]      res_h;
  logic            res_e;
  logic [2:0]      res_c;

`ifdef SENSOR_ACQ_STABLE_EN
  logic [7:0]      cand_h;
  logic            cand_e;
  logic [2:0]      cand_c;
  logic            cand_valid;
`endif

  // One restoring-division step: shift the next dividend bit into the
  // remainder, subtract the divisor when it fits and shift in the quotient bit.
  function automatic logic [12:0] div_step(input logic [2:0] r, input logic [9:0] q,
                                           input logic [2:0] d);
    logic [3:0] r2;
    logic       take;
    r2   = {r, q[9]};
    take = (r2 >= {1'b0, d});
    return {(take ? (r2[2:0] - d) : r2[2:0]), q[8:0], take};
  endfunction

  assign cur_sample = samples[acc_idx[1:0]];
  assign dividend   = sum + {8'd0, cnt[2:1]};
  assign first_step = div_step(3'd0, dividend, cnt);
  assign next_step  = div_step(rem, quo, cnt);

  always_comb begin
    commit = 1'b0;
    res_h  = 8'd0;
    res_e  = 1'b0;
    res_c  = 3'd0;
    if (state == ST_ACC && acc_idx[2] && cnt == 3'd0) begin
      commit = 1'b1;
      res_e  = 1'b1;
    end else if (state == ST_DIV && div_cnt == 4'd9) begin
      commit = 1'b1;
      res_h  = next_step[7:0];
      res_c  = cnt;
    end
  end

`ifdef SENSOR_ACQ_STABLE_EN
  assign publish = commit && cand_valid && ({cand_h, cand_e, cand_c} == {res_h, res_e, res_c});
`else
  assign publish = commit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      samples  <= '0;
      acc_idx  <= 3'd0;
      sum      <= 10'd0;
      cnt      <= 3'd0;
      rem      <= 3'd0;
      quo      <= 10'd0;
      div_cnt  <= 4'd0;
      height_r <= 8'd0;
      err_r    <= 1'b0;
      vcnt_r   <= 3'd0;
`ifdef SENSOR_ACQ_STABLE_EN
      cand_h     <= 8'd0;
      cand_e     <= 1'b0;
      cand_c     <= 3'd0;
      cand_valid <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          samples <= {bus.sensor4, bus.sensor3, bus.sensor2, bus.sensor1};
          sum     <= 10'd0;
          cnt     <= 3'd0;
          acc_idx <= 3'd0;
          state   <= ST_ACC;
        end
        ST_ACC: begin
          if (!acc_idx[2]) begin
            if (cur_sample != 8'd0) begin
              sum <= sum + {2'b00, cur_sample};
              cnt <= cnt + 3'd1;
            end
            acc_idx <= acc_idx + 3'd1;
          end else if (cnt != 3'd0) begin
            // The exit edge already performs the first of the ten division steps.
            {rem, quo} <= first_step;
            div_cnt    <= 4'd1;
            state      <= ST_DIV;
          end
        end
        ST_DIV: begin
          {rem, quo} <= next_step;
          div_cnt    <= div_cnt + 4'd1;
        end
        ST_OUT: begin
          if (bus.height_ready) begin
            state <= ST_IDLE;
`ifdef SENSOR_ACQ_STABLE_EN
            cand_valid <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (publish) begin
        height_r <= res_h;
        err_r    <= res_e;
        vcnt_r   <= res_c;
        state    <= ST_OUT;
      end
`ifdef SENSOR_ACQ_STABLE_EN
      // A retry re-captures the sensors on this edge and goes straight to accumulation.
      else if (commit) begin
        cand_h     <= res_h;
        cand_e     <= res_e;
        cand_c     <= res_c;
        cand_valid <= 1'b1;
        samples    <= {bus.sensor4, bus.sensor3, bus.sensor2, bus.sensor1};
        sum        <= 10'd0;
        cnt        <= 3'd0;
        acc_idx    <= 3'd0;
        state      <= ST_ACC;
      end
`endif
    end
  end

  assign bus.height       = height_r;
  assign bus.height_valid = (state == ST_OUT);
  assign bus.sensor_err   = err_r;
  assign bus.valid_cnt    = vcnt_r;
  assign bus.busy         = (state != ST_IDLE);

endmodule
